// File: rtl/cam_capture.sv
// Parallel camera capture: assembles BPP bytes into a pixel, tracks x/y, counts frames, flags line/frame size errors.
// Latency: pixel_valid one cycle after the last byte of a pixel; no backpressure, the camera is free-running.
module cam_capture #(
  parameter int DATA_W    = 8,
  parameter int BPP       = 2,
  parameter int MSB_FIRST = 1,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  localparam int XW = $clog2(H_ACTIVE + 1),
  localparam int YW = $clog2(V_ACTIVE + 1)
) (
  input  logic                  pclk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  href,
  input  logic [DATA_W-1:0]     d,
  input  logic                  enable,
  input  logic                  clear_err,
  output logic [DATA_W*BPP-1:0] pixel,
  output logic                  pixel_valid,
  output logic [XW-1:0]         x,
  output logic [YW-1:0]         y,
  output logic                  sof,
  output logic                  eol,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt,
  output logic                  line_err,
  output logic                  frame_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_VS_HI, S_WAIT_VS_LO, S_FRAME, S_END} state_t;

  localparam logic [XW-1:0] LP_H    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] LP_V    = YW'(V_ACTIVE);
  localparam logic [1:0]    LP_LAST = 2'(BPP - 1);

  state_t                  r_state;
  logic                    r_vsync_d, r_href_d;
  logic [1:0]              r_byte_cnt;
  logic [DATA_W-1:0]       r_bytes [BPP];
  logic [XW-1:0]           r_pcnt, r_x;
  logic [YW-1:0]           r_y;
  logic                    r_line_got;
  logic [DATA_W*BPP-1:0]   r_pixel;
  logic                    r_pixel_valid, r_sof, r_eol, r_frame_done;
  logic [15:0]             r_frame_cnt;
  logic                    r_line_err, r_frame_err;

  logic                    w_vs_rise, w_in_frame, w_end_go, w_line_ok;
  logic                    w_byte, w_pix_done, w_pix_drop, w_line_end;
  logic                    w_line_set, w_frame_set;
  logic [DATA_W*BPP-1:0]   w_pix_asm;

  assign w_vs_rise  = vsync & ~r_vsync_d;
  assign w_in_frame = (r_state == S_FRAME);
  assign w_end_go   = w_in_frame & w_vs_rise;
  assign w_line_ok  = (r_y < LP_V);
  assign w_byte     = w_in_frame & ~w_vs_rise & href & w_line_ok;
  assign w_pix_done = w_byte & (r_byte_cnt == LP_LAST);
  assign w_pix_drop = w_pix_done & (r_pcnt >= LP_H);
  // A falling href only closes a line that actually delivered bytes.
  assign w_line_end = w_in_frame & ~w_vs_rise & ~href & r_href_d & r_line_got;
  assign w_line_set = w_pix_drop |
                      (w_line_end & ((r_byte_cnt != 2'd0) | (r_pcnt != LP_H)));
  assign w_frame_set = (w_in_frame & ~w_vs_rise & href & ~w_line_ok) |
                       (w_end_go & (r_y != LP_V));

  // The final byte is taken straight from d, so the pixel is ready on the completing edge.
  always_comb begin
    w_pix_asm = '0;
    for (int i = 0; i < BPP; i++) begin
      if (MSB_FIRST != 0)
        w_pix_asm[(BPP-1-i)*DATA_W +: DATA_W] = (i == BPP-1) ? d : r_bytes[i];
      else
        w_pix_asm[i*DATA_W +: DATA_W] = (i == BPP-1) ? d : r_bytes[i];
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BPP; i++) r_bytes[i] <= '0;
    end else begin
      for (int i = 0; i < BPP; i++)
        if (w_byte && (r_byte_cnt == 2'(i))) r_bytes[i] <= d;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_vsync_d     <= 1'b0;
      r_href_d      <= 1'b0;
      r_byte_cnt    <= 2'd0;
      r_pcnt        <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_got    <= 1'b0;
      r_pixel       <= '0;
      r_pixel_valid <= 1'b0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_vsync_d     <= vsync;
      r_href_d      <= href;
      r_pixel_valid <= 1'b0;
      r_sof         <= 1'b0;
      r_eol         <= 1'b0;
      r_frame_done  <= 1'b0;
      r_line_err    <= w_line_set  | (r_line_err  & ~clear_err);
      r_frame_err   <= w_frame_set | (r_frame_err & ~clear_err);
      case (r_state)
        S_IDLE:       if (enable) r_state <= S_WAIT_VS_HI;
        S_WAIT_VS_HI: if (!enable) r_state <= S_IDLE;
                      else if (vsync) r_state <= S_WAIT_VS_LO;
        S_WAIT_VS_LO: if (!enable) r_state <= S_IDLE;
                      else if (!vsync) r_state <= S_FRAME;
        S_FRAME: begin
          if (w_vs_rise) begin
            r_state      <= S_END;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
            r_y          <= '0;
            r_x          <= '0;
            r_pcnt       <= '0;
            r_byte_cnt   <= 2'd0;
            r_line_got   <= 1'b0;
          end else if (w_byte) begin
            r_line_got <= 1'b1;
            if (w_pix_done) begin
              r_byte_cnt <= 2'd0;
              if (!w_pix_drop) begin
                r_pixel       <= w_pix_asm;
                r_pixel_valid <= 1'b1;
                r_x           <= r_pcnt;
                r_sof         <= (r_pcnt == '0) && (r_y == '0);
                r_pcnt        <= r_pcnt + XW'(1);
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
            end
          end else if (w_line_end) begin
            r_eol      <= 1'b1;
            r_byte_cnt <= 2'd0;
            r_pcnt     <= '0;
            r_x        <= '0;
            r_line_got <= 1'b0;
            r_y        <= r_y + YW'(1);
          end
        end
        S_END:   r_state <= enable ? S_WAIT_VS_LO : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pixel       = r_pixel;
  assign pixel_valid = r_pixel_valid;
  assign x           = r_x;
  assign y           = r_y;
  assign sof         = r_sof;
  assign eol         = r_eol;
  assign frame_done  = r_frame_done;
  assign frame_cnt   = r_frame_cnt;
  assign line_err    = r_line_err;
  assign frame_err   = r_frame_err;

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 Parameter DATA_W, default 8: camera data bus width.
REQ-002 Parameter BPP, default 2, legal range 1..4: bytes per pixel.
REQ-003 Parameter MSB_FIRST, default 1: 1 = first byte goes to pixel MSBs; 0 = first byte goes to LSBs.
REQ-004 Parameter H_ACTIVE, default 640: pixels per line.
REQ-005 Parameter V_ACTIVE, default 480: lines per frame.
REQ-006 Derived widths: XW = clog2(H_ACTIVE+1), YW = clog2(V_ACTIVE+1).
REQ-007 pclk  in  1: single clock; all logic on rising edge.
REQ-008 rst_n  in  1: asynchronous, active-low reset.
REQ-009 vsync  in  1: frame sync; high = vertical blanking.
REQ-010 href  in  1: line-valid qualifier.
REQ-011 d  in  DATA_W: camera data, sampled when href=1.
REQ-012 enable  in  1: capture request.
REQ-013 clear_err  in  1: synchronous clear of the sticky error flags.
REQ-014 pixel  out  DATA_W*BPP: assembled pixel.
REQ-015 pixel_valid  out  1: one-cycle strobe qualifying pixel, x, y.
REQ-016 x  out  XW: column of the current pixel.
REQ-017 y  out  YW: row of the current pixel.
REQ-018 sof  out  1: asserted with pixel_valid for pixel (0,0).
REQ-019 eol  out  1: one-cycle pulse after each line ends.
REQ-020 frame_done  out  1: one-cycle pulse at frame end.
REQ-021 frame_cnt  out  16: completed-frame counter; wraps at 0xFFFF->0.
REQ-022 line_err  out  1: sticky error flag for line length.
REQ-023 frame_err  out  1: sticky error flag for frame height.

Function
REQ-024 FSM states:
- IDLE -> WAIT_VS_HI when enable=1.
- WAIT_VS_HI -> WAIT_VS_LO when vsync=1.
- WAIT_VS_LO -> FRAME when vsync=0.
- FRAME -> END on a vsync rising edge (vsync=1 while registered vsync_d=0).
- END -> WAIT_VS_LO if enable=1; END -> IDLE otherwise; END lasts one cycle.
REQ-025 enable deassert mid-frame does not abort capture; it takes effect only in END. Deassert in WAIT_* returns to IDLE next cycle.
REQ-026 In FRAME with href=1: each cycle stores d into byte slot byte_cnt, then byte_cnt increments. At byte_cnt=BPP-1 the pixel is complete and byte_cnt returns to 0.
REQ-027 Latency: pixel_valid is asserted the cycle after the last byte of a pixel is sampled, with pixel, x and y stable for that cycle.
REQ-028 x starts at 0 per line and increments after each pixel_valid. y starts at 0 per frame.
REQ-029 Pixels with x >= H_ACTIVE are dropped (no pixel_valid) and line_err is set.
REQ-030 On an href falling edge in FRAME:
- eol pulses the next cycle.
- A partial pixel (byte_cnt != 0) is discarded and sets line_err.
- A pixel count != H_ACTIVE sets line_err.
- byte_cnt and x clear.
- y increments if at least one byte was received on that line.
REQ-031 Lines arriving with y >= V_ACTIVE are dropped entirely and set frame_err.
REQ-032 In END:
- frame_done pulses.
- frame_cnt increments.
- frame_err is set if y != V_ACTIVE.
- y, x and byte_cnt clear.
REQ-033 href=1 in IDLE, WAIT_VS_HI or WAIT_VS_LO is ignored; no outputs toggle.
REQ-034 A vsync rising edge with href=1 in the same cycle: END wins, and the byte is discarded.
REQ-035 clear_err=1 clears both error flags. If set and clear conditions occur in the same cycle, set wins.
REQ-036 BPP=1: every href=1 byte yields one pixel, and byte_cnt stays 0.

Reset
REQ-037 While rst_n=0, the following are held at reset values:
- FSM = IDLE.
- pixel = 0, pixel_valid = 0, x = 0, y = 0.
- sof, eol, frame_done = 0.
- frame_cnt = 0.
- line_err, frame_err = 0.
- byte_cnt, vsync_d, href_d = 0.
REQ-038 Reset mid-frame discards all partial data. After release, capture resumes only after a full vsync high->low sequence.

Verification
REQ-039 Scenarios, with H_ACTIVE=4, V_ACTIVE=2, BPP=2, MSB_FIRST=1 unless noted:
- Nominal frame: enable=1, vsync pulse, then 2 lines of bytes 0x12,0x34,... -> 8 pixel_valid strobes; first pixel=0x1234 with sof=1 at (0,0); 2 eol pulses; frame_done=1; frame_cnt=1; no errors.
- Odd byte count: a line of 7 bytes -> 3 pixels, last byte dropped, line_err=1. clear_err -> line_err=0.
- Overlong frame: 3 lines -> the third line produces no pixel_valid; frame_err=1 at frame_done.
- Mid-frame reset: rst_n low after 3 pixels -> all outputs 0. Next frame starts at (0,0) only after vsync high->low.
- enable drop mid-frame: frame completes (frame_done=1), then FSM goes to IDLE, and the next frame is ignored.
- BPP=1, MSB_FIRST=0, H_ACTIVE=4: bytes 0xA0..0xA3 -> 4 pixels equal to the bytes, x=0..3.
